// File: rtl/spi_axi_regs.sv
// rtl/spi_axi_regs.sv - AXI4-Lite register bank and launch control for the SPI master engine
module spi_axi_regs #(
  parameter int         ADDR_W    = 5,
  parameter logic [7:0] IFG_RST   = 8'd4,
  parameter logic [7:0] CSSCK_RST = 8'd2
) (
  input  logic              GCLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [1:0]        spi_mode,
  output logic [1:0]        sck_speed,
  output logic [1:0]        word_len,
  output logic [7:0]        t_IFG,
  output logic [7:0]        t_CS_SCK,
  output logic [7:0]        t_SCK_CS,
  output logic              start,
  output logic [31:0]       mosi_data,
  input  logic              busy,
  input  logic [31:0]       miso_data,
  output logic              irq
);

  localparam int IW = ADDR_W - 2;
  localparam logic [IW-1:0] A_CTRL   = IW'(0);
  localparam logic [IW-1:0] A_STATUS = IW'(1);
  localparam logic [IW-1:0] A_TIMING = IW'(2);
  localparam logic [IW-1:0] A_TXDATA = IW'(3);
  localparam logic [IW-1:0] A_RXDATA = IW'(4);
  localparam logic [1:0]    OKAY     = 2'b00;
  localparam logic [1:0]    SLVERR   = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_LAUNCH, ST_RUN} st_t;

  st_t           st;
  logic          ie;
  logic          done;
  logic [31:0]   rx_q;
  logic          wr_pulse;
  logic          rd_pulse;
  logic          pend;
  logic          stat_busy;
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;
  logic          wr_cfg;
  logic          wr_mapped;
  logic          wr_cfg_ok;
  logic          launch;
  logic          done_clr;
  logic [31:0]   rd_mux;
  logic          rd_err;
  logic          unused_addr_lsbs;

  assign unused_addr_lsbs = ^{s_awaddr[1:0], s_araddr[1:0]};

  assign widx      = s_awaddr[ADDR_W-1:2];
  assign ridx      = s_araddr[ADDR_W-1:2];
  assign pend      = (st != ST_IDLE);
  assign stat_busy = pend | busy;
  assign s_awready = wr_pulse;
  assign s_wready  = wr_pulse;
  assign s_arready = rd_pulse;
  assign irq       = done & ie;

  // Decode the write in its handshake cycle; config writes are frozen while a transfer is in flight
  always_comb begin
    wr_cfg    = (widx == A_CTRL) || (widx == A_TIMING) || (widx == A_TXDATA);
    wr_mapped = wr_cfg || (widx == A_STATUS) || (widx == A_RXDATA);
    wr_cfg_ok = wr_pulse && wr_cfg && !stat_busy;
    launch    = wr_cfg_ok && (widx == A_CTRL) && s_wstrb[1] && s_wdata[8];
    done_clr  = wr_pulse && (widx == A_STATUS) && s_wstrb[0] && s_wdata[1];
  end

  // Read mux; START is write-only and always reads back as 0
  always_comb begin
    rd_mux = 32'd0;
    rd_err = 1'b0;
    case (ridx)
      A_CTRL:   rd_mux = {22'd0, ie, 3'd0, word_len, sck_speed, spi_mode};
      A_STATUS: rd_mux = {30'd0, done, stat_busy};
      A_TIMING: rd_mux = {8'd0, t_SCK_CS, t_CS_SCK, t_IFG};
      A_TXDATA: rd_mux = mosi_data;
      A_RXDATA: rd_mux = rx_q;
      default:  rd_err = 1'b1;
    endcase
  end

  // Write channel: one-cycle ready pulse, then a held response until the master takes it
  always_ff @(posedge GCLK) begin
    if (RST) begin
      wr_pulse <= 1'b0;
      s_bvalid <= 1'b0;
      s_bresp  <= OKAY;
    end else begin
      wr_pulse <= s_awvalid && s_wvalid && !s_bvalid && !wr_pulse;
      if (wr_pulse) begin
        s_bvalid <= 1'b1;
        s_bresp  <= (!wr_mapped || (wr_cfg && stat_busy)) ? SLVERR : OKAY;
      end else if (s_bvalid && s_bready) begin
        s_bvalid <= 1'b0;
      end
    end
  end

  // Read channel: data is captured during the ready pulse and held until accepted
  always_ff @(posedge GCLK) begin
    if (RST) begin
      rd_pulse <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata  <= 32'd0;
      s_rresp  <= OKAY;
    end else begin
      rd_pulse <= s_arvalid && !s_rvalid && !rd_pulse;
      if (rd_pulse) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_mux;
        s_rresp  <= rd_err ? SLVERR : OKAY;
      end else if (s_rvalid && s_rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  // Configuration, timing and TX registers with per-byte strobes
  always_ff @(posedge GCLK) begin
    if (RST) begin
      spi_mode  <= 2'd0;
      sck_speed <= 2'd0;
      word_len  <= 2'd0;
      ie        <= 1'b0;
      t_IFG     <= IFG_RST;
      t_CS_SCK  <= CSSCK_RST;
      t_SCK_CS  <= CSSCK_RST;
      mosi_data <= 32'd0;
    end else if (wr_cfg_ok) begin
      case (widx)
        A_CTRL: begin
          if (s_wstrb[0]) begin
            spi_mode  <= s_wdata[1:0];
            sck_speed <= s_wdata[3:2];
            word_len  <= s_wdata[5:4];
          end
          if (s_wstrb[1]) ie <= s_wdata[9];
        end
        A_TIMING: begin
          if (s_wstrb[0]) t_IFG    <= s_wdata[7:0];
          if (s_wstrb[1]) t_CS_SCK <= s_wdata[15:8];
          if (s_wstrb[2]) t_SCK_CS <= s_wdata[23:16];
        end
        A_TXDATA: begin
          for (int b = 0; b < 4; b++) begin
            if (s_wstrb[b]) mosi_data[8*b +: 8] <= s_wdata[8*b +: 8];
          end
        end
        default: ;
      endcase
    end
  end

  // Launch FSM with DONE/RXDATA capture; a completion in the same cycle as a W1C keeps DONE set
  always_ff @(posedge GCLK) begin
    if (RST) begin
      st    <= ST_IDLE;
      start <= 1'b0;
      done  <= 1'b0;
      rx_q  <= 32'd0;
    end else begin
      if (done_clr) done <= 1'b0;
      case (st)
        ST_IDLE: begin
          if (launch) begin
            st    <= ST_LAUNCH;
            start <= 1'b1;
          end
        end
        ST_LAUNCH: begin
          if (busy) begin
            st    <= ST_RUN;
            start <= 1'b0;
          end
        end
        ST_RUN: begin
          if (!busy) begin
            st   <= ST_IDLE;
            rx_q <= miso_data;
            done <= 1'b1;
          end
        end
        default: begin
          st    <= ST_IDLE;
          start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_axi_regs.sv
// tb/tb_spi_axi_regs.sv - scoreboard bench for spi_axi_regs with a loopback engine model
module tb_spi_axi_regs;

  logic        GCLK = 1'b0;
  logic        RST;
  logic [4:0]  s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [4:0]  s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic [1:0]  spi_mode;
  logic [1:0]  sck_speed;
  logic [1:0]  word_len;
  logic [7:0]  t_IFG;
  logic [7:0]  t_CS_SCK;
  logic [7:0]  t_SCK_CS;
  logic        start;
  logic [31:0] mosi_data;
  logic        busy;
  logic [31:0] miso_data;
  logic        irq;

  always #5 GCLK = ~GCLK;

  spi_axi_regs #(.ADDR_W(5), .IFG_RST(8'd4), .CSSCK_RST(8'd2)) dut (
    .GCLK(GCLK), .RST(RST),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .spi_mode(spi_mode), .sck_speed(sck_speed), .word_len(word_len),
    .t_IFG(t_IFG), .t_CS_SCK(t_CS_SCK), .t_SCK_CS(t_SCK_CS),
    .start(start), .mosi_data(mosi_data), .busy(busy), .miso_data(miso_data), .irq(irq)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard queues filled by the stimulus tasks
  logic [1:0]  exp_b[$];
  string       name_b[$];
  logic [33:0] exp_r[$];
  string       name_r[$];
  string       mon_bn;
  logic [1:0]  mon_be;
  string       mon_rn;
  logic [33:0] mon_re;

  // Monitor: compare each response as the DUT presents it and the master accepts it
  always @(negedge GCLK) begin
    if (s_bvalid && s_bready) begin
      if (exp_b.size() == 0) begin
        check("bresp_unexpected", 32'(s_bvalid), 32'd0);
      end else begin
        mon_bn = name_b.pop_front();
        mon_be = exp_b.pop_front();
        check({mon_bn, "_bresp"}, 32'(s_bresp), 32'(mon_be));
      end
    end
    if (s_rvalid && s_rready) begin
      if (exp_r.size() == 0) begin
        check("rdata_unexpected", 32'(s_rvalid), 32'd0);
      end else begin
        mon_rn = name_r.pop_front();
        mon_re = exp_r.pop_front();
        check({mon_rn, "_rdata"}, s_rdata, mon_re[31:0]);
        check({mon_rn, "_rresp"}, 32'(s_rresp), 32'(mon_re[33:32]));
      end
    end
  end

  // Launch tracking: number of start pulses and length of the last one
  int   start_rises    = 0;
  int   start_len      = 0;
  int   last_start_len = 0;
  logic start_d        = 1'b0;
  always @(negedge GCLK) begin
    if (start && !start_d) start_rises <= start_rises + 1;
    if (start) start_len <= start_len + 1;
    else if (start_d) begin
      last_start_len <= start_len;
      start_len      <= 0;
    end
    start_d <= start;
  end

  // Engine model: waits eng_delay cycles after start, then busy for eng_len cycles, looping mosi to miso
  int          eng_delay = 3;
  int          eng_len   = 4;
  int          eng_cnt;
  int          eng_phase;
  int          transfers = 0;
  logic [31:0] eng_word;
  logic        rst_seen;
  initial begin
    busy = 1'b0;
    miso_data = 32'd0;
    eng_phase = 0;
    eng_cnt = 0;
    eng_word = 32'd0;
    forever begin
      @(posedge GCLK);
      rst_seen = RST;
      #2;
      if (rst_seen) begin
        busy = 1'b0;
        eng_phase = 0;
      end else begin
        case (eng_phase)
          0: if (start) begin eng_cnt = eng_delay; eng_phase = 1; end
          1: begin
            if (eng_cnt <= 1) begin
              busy = 1'b1;
              eng_word = mosi_data;
              eng_cnt = eng_len;
              eng_phase = 2;
              transfers++;
            end else eng_cnt--;
          end
          2: begin
            if (eng_cnt <= 1) begin
              miso_data = eng_word;
              busy = 1'b0;
              eng_phase = 0;
            end else eng_cnt--;
          end
          default: eng_phase = 0;
        endcase
      end
    end
  end

  task automatic axi_write(input string name, input logic [4:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp, input int hold);
    bit got;
    bit stable;
    logic [1:0] r0;
    exp_b.push_back(exp);
    name_b.push_back(name);
    s_awaddr = addr; s_wdata = data; s_wstrb = strb;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge GCLK); #1;
      if (s_awready && s_wready) begin got = 1'b1; break; end
    end
    if (!got) begin
      check({name, "_awready_timeout"}, 32'd0, 32'd1);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      void'(exp_b.pop_back()); void'(name_b.pop_back());
      return;
    end
    @(posedge GCLK); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    check({name, "_bvalid_lat"}, 32'({s_awready, s_bvalid}), 32'b01);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (s_bvalid) got = 1'b1;
      else begin @(posedge GCLK); #1; end
    end
    if (!got) begin
      check({name, "_bvalid_timeout"}, 32'd0, 32'd1);
      void'(exp_b.pop_back()); void'(name_b.pop_back());
      return;
    end
    r0 = s_bresp;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge GCLK); #1;
      if (!s_bvalid || s_bresp !== r0) stable = 1'b0;
    end
    if (hold > 0) check({name, "_bhold_stable"}, 32'(stable), 32'd1);
    s_bready = 1'b1;
    @(posedge GCLK); #1;
    s_bready = 1'b0;
  endtask

  task automatic axi_read(input string name, input logic [4:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int hold);
    bit got;
    bit stable;
    logic [31:0] d0;
    logic [1:0]  r0;
    exp_r.push_back({exp_resp, exp_data});
    name_r.push_back(name);
    s_araddr = addr; s_arvalid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge GCLK); #1;
      if (s_arready) begin got = 1'b1; break; end
    end
    if (!got) begin
      check({name, "_arready_timeout"}, 32'd0, 32'd1);
      s_arvalid = 1'b0;
      void'(exp_r.pop_back()); void'(name_r.pop_back());
      return;
    end
    @(posedge GCLK); #1;
    s_arvalid = 1'b0;
    check({name, "_rvalid_lat"}, 32'({s_arready, s_rvalid}), 32'b01);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (s_rvalid) got = 1'b1;
      else begin @(posedge GCLK); #1; end
    end
    if (!got) begin
      check({name, "_rvalid_timeout"}, 32'd0, 32'd1);
      void'(exp_r.pop_back()); void'(name_r.pop_back());
      return;
    end
    d0 = s_rdata; r0 = s_rresp;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge GCLK); #1;
      if (!s_rvalid || s_rdata !== d0 || s_rresp !== r0) stable = 1'b0;
    end
    if (hold > 0) check({name, "_rhold_stable"}, 32'(stable), 32'd1);
    s_rready = 1'b1;
    @(posedge GCLK); #1;
    s_rready = 1'b0;
  endtask

  task automatic wait_busy(input string name, input int bound);
    bit held;
    bit got;
    held = 1'b1; got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge GCLK); #1;
      if (busy) begin got = 1'b1; break; end
      if (!start) held = 1'b0;
    end
    check({name, "_busy_seen"}, 32'(got), 32'd1);
    check({name, "_start_held"}, 32'(held), 32'd1);
    check({name, "_start_drop"}, 32'(start), 32'd0);
  endtask

  task automatic wait_irq(input string name, input int bound);
    bit got;
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(posedge GCLK); #1;
      if (irq) begin got = 1'b1; break; end
    end
    check({name, "_irq"}, 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [1:0] OK = 2'b00;
  localparam logic [1:0] SE = 2'b10;

  initial begin
    RST = 1'b1;
    s_awaddr = 5'd0; s_awvalid = 1'b0; s_wdata = 32'd0; s_wstrb = 4'd0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = 5'd0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (3) @(posedge GCLK);
    #1 RST = 1'b0;

    // Reset state of all outputs
    check("rst_handshake", 32'({s_awready, s_wready, s_bvalid, s_arready, s_rvalid}), 32'd0);
    check("rst_resp_data", {s_rdata[29:0], s_bresp} | 32'(s_rresp), 32'd0);
    check("rst_start_irq", 32'({start, irq}), 32'd0);
    check("rst_timing", {8'd0, t_SCK_CS, t_CS_SCK, t_IFG}, 32'h0002_0204);
    check("rst_cfg", 32'({spi_mode, sck_speed, word_len}), 32'd0);
    check("rst_mosi", mosi_data, 32'd0);

    axi_read("rd_ctrl0",   5'h00, 32'd0, OK, 0);
    axi_read("rd_status0", 5'h04, 32'd0, OK, 0);
    axi_read("rd_timing0", 5'h08, 32'h0002_0204, OK, 0);
    axi_read("rd_tx0",     5'h0C, 32'd0, OK, 0);
    axi_read("rd_rx0",     5'h10, 32'd0, OK, 0);
    axi_read("rd_unmap14", 5'h14, 32'd0, SE, 0);

    // Basic loopback transfer with interrupt
    eng_delay = 3; eng_len = 4;
    axi_write("wr_tx", 5'h0C, 32'hA5A5_0F0F, 4'hF, OK, 0);
    check("mosi_after_wr", mosi_data, 32'hA5A5_0F0F);
    axi_write("wr_ctrl_go", 5'h00, 32'h0000_0321, 4'hF, OK, 0);
    wait_busy("xfer1", 50);
    check("cfg_xfer1", 32'({spi_mode, sck_speed, word_len}), 32'b01_00_10);
    wait_irq("xfer1", 50);
    axi_read("rd_rx1",     5'h10, 32'hA5A5_0F0F, OK, 0);
    axi_read("rd_status1", 5'h04, 32'h2, OK, 0);
    axi_read("rd_ctrl1",   5'h00, 32'h221, OK, 0);
    axi_write("wr_w1c", 5'h04, 32'h2, 4'hF, OK, 0);
    check("irq_cleared", 32'(irq), 32'd0);
    axi_read("rd_status_clr", 5'h04, 32'h0, OK, 0);

    // Long inter-frame gap: start held, writes dropped while busy
    eng_delay = 300;
    axi_write("wr_ctrl_long", 5'h00, 32'h0000_0301, 4'hF, OK, 0);
    axi_read("rd_status_pend", 5'h04, 32'h1, OK, 0);
    axi_write("wr_tx_busy",   5'h0C, 32'hFFFF_FFFF, 4'hF, SE, 0);
    axi_write("wr_ctrl_busy", 5'h00, 32'h0000_0100, 4'hF, SE, 0);
    axi_write("wr_w1c_busy",  5'h04, 32'h2, 4'hF, OK, 0);
    check("mosi_unchanged", mosi_data, 32'hA5A5_0F0F);
    check("mode_unchanged", 32'(spi_mode), 32'd1);
    axi_read("rd_status_pend2", 5'h04, 32'h1, OK, 0);
    wait_busy("xfer2", 400);
    wait_irq("xfer2", 50);
    check("start_len_long", 32'(last_start_len >= 300), 32'd1);
    check("one_launch_long", 32'(start_rises), 32'd2);
    check("one_xfer_long", 32'(transfers), 32'd2);
    axi_read("rd_rx2", 5'h10, 32'hA5A5_0F0F, OK, 0);
    axi_write("wr_w1c2", 5'h04, 32'h2, 4'hF, OK, 0);

    // Byte strobes and held responses
    axi_write("wr_timing_strb", 5'h08, 32'h1234_5678, 4'b0101, OK, 10);
    check("t_ifg_strb", 32'(t_IFG), 32'h78);
    check("t_cssck_strb", 32'(t_CS_SCK), 32'h02);
    check("t_sckcs_strb", 32'(t_SCK_CS), 32'h34);
    axi_read("rd_timing_hold", 5'h08, 32'h0034_0278, OK, 10);
    axi_write("wr_unmap14", 5'h14, 32'hDEAD_BEEF, 4'hF, SE, 0);
    axi_read("rd_unmap1c", 5'h1C, 32'd0, SE, 0);

    // Reset while the engine is running
    eng_delay = 3; eng_len = 50;
    axi_write("wr_tx3", 5'h0C, 32'h1122_3344, 4'hF, OK, 0);
    axi_write("wr_ctrl3", 5'h00, 32'h0000_010D, 4'hF, OK, 0);
    wait_busy("xfer3", 50);
    repeat (3) @(posedge GCLK);
    #1 RST = 1'b1;
    @(posedge GCLK);
    #1 RST = 1'b0;
    check("rst_run_start", 32'(start), 32'd0);
    check("rst_run_cfg", 32'({spi_mode, sck_speed, word_len}), 32'd0);
    check("rst_run_timing", {8'd0, t_SCK_CS, t_CS_SCK, t_IFG}, 32'h0002_0204);
    check("rst_run_mosi", mosi_data, 32'd0);
    axi_read("rd_ctrl_rst",   5'h00, 32'd0, OK, 0);
    axi_read("rd_status_rst", 5'h04, 32'd0, OK, 0);
    axi_read("rd_timing_rst", 5'h08, 32'h0002_0204, OK, 0);
    axi_read("rd_tx_rst",     5'h0C, 32'd0, OK, 0);
    axi_read("rd_rx_rst",     5'h10, 32'd0, OK, 0);

    // Normal launch after the reset
    eng_len = 4;
    axi_write("wr_tx4", 5'h0C, 32'h5A5A_1234, 4'hF, OK, 0);
    axi_write("wr_ctrl4", 5'h00, 32'h0000_0301, 4'hF, OK, 0);
    wait_busy("xfer4", 50);
    wait_irq("xfer4", 50);
    axi_read("rd_rx4", 5'h10, 32'h5A5A_1234, OK, 0);
    axi_read("rd_status4", 5'h04, 32'h2, OK, 0);

    repeat (3) @(posedge GCLK);
    #1;
    check("total_transfers", 32'(transfers), 32'd4);
    check("total_launches", 32'(start_rises), 32'd4);
    check("sb_empty", 32'(exp_b.size() + exp_r.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
